// File: rtl/axi2npu_wr_bridge_if.sv
// Signal bundle between the accelerator AXI write port, the bridge and the NPU write channels.
// The bridge takes the slave view; the AXI master and NPU side take the master view.
interface axi2npu_wr_bridge_if #(
    parameter int DATA_W = 32,
    parameter int ID_W   = 4,
    parameter int NUM_CH = 2
);
    logic [ID_W-1:0]     acc_awid;
    logic [31:0]         acc_awaddr;
    logic [7:0]          acc_awlen;
    logic [2:0]          acc_awsize;
    logic [1:0]          acc_awburst;
    logic                acc_awvalid;
    logic                acc_awready;

    logic [DATA_W-1:0]   acc_wdata;
    logic [DATA_W/8-1:0] acc_wstrb;
    logic                acc_wlast;
    logic                acc_wvalid;
    logic                acc_wready;

    logic [ID_W-1:0]     acc_bid;
    logic [1:0]          acc_bresp;
    logic                acc_bvalid;
    logic                acc_bready;

    logic [NUM_CH-1:0]   npu_wr_sop;
    logic [NUM_CH-1:0]   npu_wr_eop;
    logic [NUM_CH-1:0]   npu_wr_vld;
    logic [DATA_W-1:0]   npu_wr_data;
    logic [NUM_CH-1:0]   npu_wr_err;

    modport slave (
        input  acc_awid, acc_awaddr, acc_awlen, acc_awsize, acc_awburst, acc_awvalid,
        output acc_awready,
        input  acc_wdata, acc_wstrb, acc_wlast, acc_wvalid,
        output acc_wready,
        output acc_bid, acc_bresp, acc_bvalid,
        input  acc_bready,
        output npu_wr_sop, npu_wr_eop, npu_wr_vld, npu_wr_data,
        input  npu_wr_err
    );

    modport master (
        output acc_awid, acc_awaddr, acc_awlen, acc_awsize, acc_awburst, acc_awvalid,
        input  acc_awready,
        output acc_wdata, acc_wstrb, acc_wlast, acc_wvalid,
        input  acc_wready,
        input  acc_bid, acc_bresp, acc_bvalid,
        output acc_bready,
        input  npu_wr_sop, npu_wr_eop, npu_wr_vld, npu_wr_data,
        output npu_wr_err
    );
endinterface

// File: rtl/axi2npu_wr_bridge.sv
// AXI4 write slave that queues bursts, steers each one to an NPU write channel chosen by
// address bits, frames beats with SOP/EOP and returns one in-order B response per burst.
module axi2npu_wr_bridge #(
    parameter int DATA_W      = 32,
    parameter int ID_W        = 4,
    parameter int OUTSTANDING = 8,
    parameter int NUM_CH      = 2,
    parameter int CH_SEL_W    = 2,
    parameter int CH_LSB      = 28
) (
    input  logic               clk,
    input  logic               rst,
    axi2npu_wr_bridge_if.slave bus
);
    localparam int PTR_W = $clog2(OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH = CNT_W'(OUTSTANDING);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic {IDLE, BURST} state_t;

    typedef struct packed {
        logic [ID_W-1:0]     id;
        logic [CH_SEL_W-1:0] ch;
        logic [7:0]          len;
        logic                dec;
    } aw_entry_t;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [1:0]      resp;
    } b_entry_t;

    // ---------------- AW queue ----------------
    aw_entry_t        aw_mem [OUTSTANDING];
    aw_entry_t        aw_in;
    logic [PTR_W-1:0] aw_wr_ptr, aw_rd_ptr;
    logic [CNT_W-1:0] aw_cnt;
    logic             aw_push, aw_pop;

    state_t           state, state_nxt;

    assign aw_in.id  = bus.acc_awid;
    assign aw_in.ch  = bus.acc_awaddr[CH_LSB +: CH_SEL_W];
    assign aw_in.len = bus.acc_awlen;
    assign aw_in.dec = (int'(aw_in.ch) >= NUM_CH);

    // A pop in the same cycle does not open a slot early.
    assign bus.acc_awready = (aw_cnt < DEPTH);
    assign aw_push         = bus.acc_awvalid && bus.acc_awready;
    assign aw_pop          = (state == IDLE) && (aw_cnt != '0);

    // NOTE: queue storage has no reset; the pointers and counts alone say which slots are valid.
    always_ff @(posedge clk) begin
        if (aw_push) aw_mem[aw_wr_ptr] <= aw_in;
    end

    // NOTE: all clocked state is written with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            aw_wr_ptr <= '0;
            aw_rd_ptr <= '0;
            aw_cnt    <= '0;
        end else begin
            if (aw_push) aw_wr_ptr <= aw_wr_ptr + PTR_W'(1);
            if (aw_pop)  aw_rd_ptr <= aw_rd_ptr + PTR_W'(1);
            case ({aw_push, aw_pop})
                2'b10:   aw_cnt <= aw_cnt + CNT_W'(1);
                2'b01:   aw_cnt <= aw_cnt - CNT_W'(1);
                default: aw_cnt <= aw_cnt;
            endcase
        end
    end

    // ---------------- W burst engine ----------------
    aw_entry_t         cur;
    logic [7:0]        beat_cnt;
    logic              err_flag;
    logic [NUM_CH-1:0] ch_onehot;
    logic              err_now;
    logic              wready;
    logic              w_hs;
    logic              b_full;
    b_entry_t          b_in;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first so no path infers a latch.
    always_comb begin
        state_nxt = state;
        wready    = 1'b0;
        case (state)
            IDLE: begin
                if (aw_cnt != '0) state_nxt = BURST;
            end
            BURST: begin
                wready = !b_full;
                if (bus.acc_wvalid && !b_full && bus.acc_wlast) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.acc_wready = wready;
    assign w_hs           = bus.acc_wvalid && wready;

    // Unmapped channels decode to an all-zero select, which also masks their error input.
    always_comb begin
        ch_onehot = '0;
        for (int i = 0; i < NUM_CH; i++) ch_onehot[i] = (int'(cur.ch) == i);
    end

    assign err_now = |(bus.npu_wr_err & ch_onehot);

    always_ff @(posedge clk) begin
        if (rst) begin
            cur      <= '0;
            beat_cnt <= '0;
            err_flag <= 1'b0;
        end else if (aw_pop) begin
            cur      <= aw_mem[aw_rd_ptr];
            beat_cnt <= '0;
            err_flag <= 1'b0;
        end else if (state == BURST) begin
            err_flag <= err_flag | err_now;
            if (w_hs && (beat_cnt != 8'hFF)) beat_cnt <= beat_cnt + 8'd1;
        end
    end

    always_comb begin
        b_in.id = cur.id;
        if (cur.dec)                                     b_in.resp = RESP_DECERR;
        else if (err_flag || err_now || beat_cnt != cur.len) b_in.resp = RESP_SLVERR;
        else                                             b_in.resp = RESP_OKAY;
    end

    // NPU outputs are single-cycle pulses registered from the W handshake.
    logic [NUM_CH-1:0] npu_vld, npu_sop, npu_eop;
    logic [DATA_W-1:0] npu_data;

    always_ff @(posedge clk) begin
        if (rst || !w_hs) begin
            npu_vld  <= '0;
            npu_sop  <= '0;
            npu_eop  <= '0;
            npu_data <= '0;
        end else begin
            npu_vld  <= ch_onehot;
            npu_sop  <= (beat_cnt == 8'd0) ? ch_onehot : '0;
            npu_eop  <= bus.acc_wlast ? ch_onehot : '0;
            npu_data <= cur.dec ? '0 : bus.acc_wdata;
        end
    end

    assign bus.npu_wr_vld  = npu_vld;
    assign bus.npu_wr_sop  = npu_sop;
    assign bus.npu_wr_eop  = npu_eop;
    assign bus.npu_wr_data = npu_data;

    // ---------------- B queue ----------------
    b_entry_t         b_mem [OUTSTANDING];
    b_entry_t         b_head;
    logic [PTR_W-1:0] b_wr_ptr, b_rd_ptr;
    logic [CNT_W-1:0] b_cnt;
    logic             b_push, b_pop, b_valid;

    assign b_push  = w_hs && bus.acc_wlast;
    assign b_valid = (b_cnt != '0);
    assign b_pop   = b_valid && bus.acc_bready;
    assign b_full  = (b_cnt == DEPTH);
    assign b_head  = b_mem[b_rd_ptr];

    assign bus.acc_bvalid = b_valid;
    assign bus.acc_bid    = b_valid ? b_head.id   : '0;
    assign bus.acc_bresp  = b_valid ? b_head.resp : '0;

    always_ff @(posedge clk) begin
        if (b_push) b_mem[b_wr_ptr] <= b_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            b_wr_ptr <= '0;
            b_rd_ptr <= '0;
            b_cnt    <= '0;
        end else begin
            if (b_push) b_wr_ptr <= b_wr_ptr + PTR_W'(1);
            if (b_pop)  b_rd_ptr <= b_rd_ptr + PTR_W'(1);
            case ({b_push, b_pop})
                2'b10:   b_cnt <= b_cnt + CNT_W'(1);
                2'b01:   b_cnt <= b_cnt - CNT_W'(1);
                default: b_cnt <= b_cnt;
            endcase
        end
    end

    // Burst type/size, byte strobes and the non-select address bits have no effect.
    logic unused_inputs;
    assign unused_inputs = ^{bus.acc_awsize, bus.acc_awburst, bus.acc_wstrb, bus.acc_awaddr};

endmodule
